spi_txn_scheduler: RTL
======================

// Module: spi_txn_scheduler
// PURPOSE
//  Shares the single SPI master among NUM_REQ on-chip requesters, round-robin.
//  Selects the target slave via m_cs, sequences each 18-bit full-duplex transfer, returns read data.
//  Sits between the requesters and the SPI master / slave-select demux in the multi-slave SPI subsystem.
//  Handles one transaction at a time, with a timeout guard on a missing mrx_data_valid.
// PARAMETERS
//  NUM_REQ         4     number of requesters (2..8)
//  DATA_W          18    SPI word width; equals master data_in/master_out width
//  SETUP_CYCLES    2     sys_clock cycles m_cs is stable before m_tx_enable (>=1)
//  GAP_CYCLES      4     idle cycles after a response before next grant (>=0)
//  TIMEOUT_CYCLES  4096  max WAIT cycles before abort (>=2)
// PORTS
//  sys_clock      in   1                 system clock, all logic rising-edge
//  reset_n        in   1                 asynchronous, active-low reset
//  req_valid      in   NUM_REQ           requester i has a transfer pending
//  req_data       in   NUM_REQ*DATA_W    requester i MOSI word, slice [i*DATA_W +: DATA_W]
//  req_slave      in   NUM_REQ           requester i target slave (0 = slave1, 1 = slave2)
//  req_ready      out  NUM_REQ           one-hot accept pulse; transfer when valid&ready
//  rsp_valid      out  1                 one-cycle response strobe (no backpressure)
//  rsp_id         out  $clog2(NUM_REQ)   index of requester owning the response
//  rsp_data       out  DATA_W            MISO word captured from master_out
//  rsp_timeout    out  1                 qualifies rsp_valid: transfer aborted, rsp_data = 0
//  busy           out  1                 high in every state except IDLE
//  m_tx_enable    out  1                 start pulse to SPI master
//  m_data_in      out  DATA_W            word to SPI master, held from grant to next grant
//  m_cs           out  1                 slave select to demux/mux, held from grant to next grant
//  m_master_out   in   DATA_W            SPI master received word
//  m_rx_valid     in   1                 SPI master mrx_data_valid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, RR pointer 0, counters 0. Reset mid-transfer aborts silently (no rsp).
//  FSM: IDLE -> SETUP -> START -> WAIT -> RESP -> GAP -> IDLE (GAP skipped if GAP_CYCLES = 0).
//  IDLE: if any req_valid, grant the first set bit searching from RR pointer upward (wrap).
//    Same cycle: req_ready[g]=1; latch req_data, req_slave, g. Next cycle m_data_in/m_cs update -> SETUP.
//    RR pointer <= g+1 (mod NUM_REQ) on grant. No request: remain IDLE, outputs hold.
//  SETUP: SETUP_CYCLES cycles, m_cs stable, m_tx_enable=0.
//  START: m_tx_enable=1 for exactly one cycle; WAIT counter cleared.
//  WAIT: counts cycles. m_rx_valid=1 -> capture m_master_out, RESP.
//    Counter reaches TIMEOUT_CYCLES-1 without m_rx_valid -> RESP with timeout flag.
//    m_rx_valid and timeout in the same cycle: data wins (rsp_timeout=0).
//  RESP: rsp_valid=1 one cycle; rsp_id=g; rsp_data/rsp_timeout valid this cycle only, 0 otherwise.
//  GAP: GAP_CYCLES cycles, no grant; req_ready all 0.
//  m_rx_valid outside WAIT is ignored. req_valid deassert after grant has no effect on the transfer.
//  req_ready never asserts outside IDLE; at most one bit set in any cycle.
//  Grant-to-m_tx_enable latency = SETUP_CYCLES+1 cycles. Min per-transfer overhead = SETUP+GAP+3 cycles.
// STRUCTURE
//  Shared package spi_ctrl_pkg: FSM state encoding (IDLE..GAP), SPI_WORD_W=18, slave select codes.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer in, one-hot grant + index out, combinational.
//  Top holds FSM, latches, SETUP/WAIT/GAP down-counters (one shared counter permitted).
// TESTING
//  Single: req_valid=0001, data 0x2A5A5, slave 0 -> req_ready=0001 same cycle; m_cs=0;
//    m_tx_enable 3 cycles after grant; m_rx_valid with 0x15A5A -> rsp_valid, rsp_id=0, rsp_data=0x15A5A.
//  Round-robin: req_valid=1111 held -> grants in order 0,1,2,3,0; never two bits of req_ready set.
//  Slave select: req 2 with slave 1 -> m_cs=1 from grant+1 through RESP, unchanged until next grant.
//  Timeout (TIMEOUT_CYCLES=16): m_rx_valid never asserted -> rsp_valid 16 cycles after WAIT entry,
//    rsp_timeout=1, rsp_data=0; next grant only after GAP.
//  Collision: m_rx_valid on the final WAIT cycle -> rsp_timeout=0, data captured.
//  Reset in WAIT: reset_n low 1 cycle -> all outputs 0 at once, no rsp_valid; next grant goes to requester 0.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transaction scheduler: FSM states, word width,
// slave-select codes and a small sizing helper.
package spi_ctrl_pkg;

    localparam int SPI_WORD_W = 18;

    localparam logic CS_SLAVE1 = 1'b0;
    localparam logic CS_SLAVE2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } sched_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index at or
// above the pointer, wrapping around, and reports it one-hot and as an index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        int   pos;
        logic found;
        pos     = 0;
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(i_ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!found && i_req[pos]) begin
                found        = 1'b1;
                o_grant[pos] = 1'b1;
                o_idx        = IDX_W'(pos);
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler sharing one SPI master among NUM_REQ requesters; runs a
// single grant -> setup -> start -> wait -> response -> gap sequence at a time.
module spi_txn_scheduler
    import spi_ctrl_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_W         = SPI_WORD_W,
    parameter  int SETUP_CYCLES   = 2,
    parameter  int GAP_CYCLES     = 4,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                      sys_clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_slave,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      m_tx_enable,
    output logic [DATA_W-1:0]         m_data_in,
    output logic                      m_cs,
    input  logic [DATA_W-1:0]         m_master_out,
    input  logic                      m_rx_valid
);

    localparam int CNT_W = $clog2(max3(TIMEOUT_CYCLES, SETUP_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t        r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic                r_cs;
    logic                r_tx_en;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_to;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_gidx;
    logic                w_any;
    logic [ID_W-1:0]     w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_ptr_next = (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + ID_W'(1);

    // Grants are only offered while idle; the accept pulse is combinational so
    // the requester sees it in the same cycle it presents valid.
    assign req_ready   = (r_state == ST_IDLE) ? w_grant : '0;
    assign busy        = (r_state != ST_IDLE);
    assign m_tx_enable = r_tx_en;
    assign m_data_in   = r_data;
    assign m_cs        = r_cs;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_to;

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_id        <= '0;
            r_data      <= '0;
            r_cs        <= CS_SLAVE1;
            r_tx_en     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_to    <= 1'b0;
        end else begin
            r_tx_en     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_to    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_data  <= req_data[int'(w_gidx)*DATA_W +: DATA_W];
                        r_cs    <= req_slave[w_gidx] ? CS_SLAVE2 : CS_SLAVE1;
                        r_id    <= w_gidx;
                        r_ptr   <= w_ptr_next;
                        r_cnt   <= SETUP_LAST;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_tx_en <= 1'b1;
                        r_state <= ST_START;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                // Received data takes priority over a timeout landing on the same cycle.
                ST_WAIT: begin
                    if (m_rx_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_data  <= m_master_out;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_to    <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (GAP_CYCLES > 0) begin
                        r_cnt   <= GAP_LAST;
                        r_state <= ST_GAP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
